// File: rtl/ram_dp_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external dual-port synchronous RAM.
// Writes use the primary port; the head word is read back through the secondary port.
module ram_dp_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err,
  input  logic                  flush,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_pa,
  output logic [ADDR_WIDTH-1:0] ram_sa,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_sdo
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  empty_w;
  logic                  full_w;
  logic                  pop_ok;
  logic                  push_ok;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A push into a full FIFO is only admitted when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty_w & ~flush;
  assign push_ok = push & ~flush & (~full_w | pop_ok);

  // The secondary address is presented before the edge so the RAM registers the
  // new head address; after the edge ram_sdo already shows mem[rd_ptr].
  always_comb begin
    rd_ptr_next = rd_ptr_q + ADDR_WIDTH'(pop_ok);
    if (reset || flush) begin
      rd_ptr_next = '0;
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q + ADDR_WIDTH'(push_ok);
    rd_ptr_d       = rd_ptr_next;
    count_d        = count_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end
    almost_full_d  = (count_d >= AFULL_C);
    almost_empty_d = (count_d <= AEMPTY_C);
  end

  // A fresh error event in the same cycle as clear_err keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q  & ~clear_err) | (push & ~flush & full_w & ~pop_ok);
    underflow_d = (underflow_q & ~clear_err) | (pop & empty_w & ~flush);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      almost_full_q  <= (AFULL_C == '0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd_data      = ram_sdo;
  assign empty        = empty_w;
  assign full         = full_w;
  assign count        = count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign ram_we = push_ok & ~reset;
  assign ram_pa = wr_ptr_q;
  assign ram_sa = rd_ptr_next;
  assign ram_di = wr_data;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Directed bench for ram_dp_fifo_ctrl with a behavioural dual-port RAM beside it
// (DEPTH 4, almost_full at 3, almost_empty at 1).
module tb_ram_dp_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          push;
  logic [DW-1:0] wr_data;
  logic          pop;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic          clear_err;
  logic          flush;
  logic          ram_we;
  logic [AW-1:0] ram_pa;
  logic [AW-1:0] ram_sa;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_sdo;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_dp_fifo_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (3),
    .AEMPTY_LEVEL(1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .wr_data     (wr_data),
    .pop         (pop),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .clear_err   (clear_err),
    .flush       (flush),
    .ram_we      (ram_we),
    .ram_pa      (ram_pa),
    .ram_sa      (ram_sa),
    .ram_di      (ram_di),
    .ram_sdo     (ram_sdo)
  );

  // Synchronous RAM: both addresses registered, secondary read is mem[registered addr].
  logic [DW-1:0] mem [4];
  logic [AW-1:0] sa_q;
  always @(posedge clock) begin
    if (ram_we) mem[ram_pa] <= ram_di;
    sa_q <= ram_sa;
  end
  assign ram_sdo = mem[sa_q];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [AW:0] obs, input logic [AW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [DW-1:0] d, input logic o,
                       input logic f, input logic c);
    push = p; wr_data = d; pop = o; flush = f; clear_err = c;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("reset_we_low", ram_we, 1'b0);
    chk8("reset_sa_zero", {6'd0, ram_sa}, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    chkc("rst_count", count, 3'd0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_afull", almost_full, 1'b0);
    chk1("rst_aempty", almost_empty, 1'b1);
    chk1("rst_ovf", overflow, 1'b0);
    chk1("rst_udf", underflow, 1'b0);

    // Single push then pop
    drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0); tick();
    chk1("t1_empty", empty, 1'b0);
    chkc("t1_count", count, 3'd1);
    chk8("t1_rd", rd_data, 8'hA1);
    chk1("t1_aempty", almost_empty, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk1("t1_empty2", empty, 1'b1);
    chkc("t1_count2", count, 3'd0);

    // Fill, overflow, drain
    drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0); tick();
    chk1("t2_aempty1", almost_empty, 1'b1);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    chk1("t2_aempty2", almost_empty, 1'b0);
    chk1("t2_afull2", almost_full, 1'b0);
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0); tick();
    chk1("t2_afull3", almost_full, 1'b1);
    chk1("t2_full3", full, 1'b0);
    drive(1'b1, 8'h13, 1'b0, 1'b0, 1'b0); tick();
    chk1("t2_full4", full, 1'b1);
    chkc("t2_count4", count, 3'd4);
    drive(1'b1, 8'h14, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("t2_we_rejected", ram_we, 1'b0);
    tick();
    chk1("t2_ovf", overflow, 1'b1);
    chkc("t2_count_ovf", count, 3'd4);
    for (int i = 0; i < 4; i++) begin
      chk8("t2_rd", rd_data, 8'h10 + 8'(i));
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    end
    chk1("t2_empty", empty, 1'b1);
    chk1("t2_ovf_sticky", overflow, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); tick();
    chk1("t2_ovf_clear", overflow, 1'b0);

    // Wrap with one or two words in flight
    drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 1; i < 10; i++) begin
      chk8("t3_rd", rd_data, 8'h20 + 8'(i - 1));
      drive(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0, 1'b0); tick();
      chkc("t3_count", count, 3'd1);
    end
    chk8("t3_rd_last", rd_data, 8'h29);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk1("t3_empty", empty, 1'b1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0); tick();
    end
    chk8("t4_head", rd_data, 8'h10);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    #1;
    chk1("t4_we", ram_we, 1'b1);
    tick();
    chkc("t4_count", count, 3'd4);
    chk1("t4_ovf", overflow, 1'b0);
    chk8("t4_rd0", rd_data, 8'h11);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk8("t4_rd1", rd_data, 8'h12);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk8("t4_rd2", rd_data, 8'h13);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk8("t4_rd3", rd_data, 8'h55);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk1("t4_empty", empty, 1'b1);

    // Empty with simultaneous pop and push
    drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0); tick();
    chk1("t5_udf", underflow, 1'b1);
    chkc("t5_count", count, 3'd1);
    chk8("t5_rd", rd_data, 8'h66);

    // Flush with push; error flags held
    drive(1'b1, 8'h67, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h68, 1'b0, 1'b0, 1'b0); tick();
    chkc("t6_count3", count, 3'd3);
    chk1("t6_afull3", almost_full, 1'b1);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    #1;
    chk1("t6_flush_we", ram_we, 1'b0);
    tick();
    chkc("t6_count0", count, 3'd0);
    chk1("t6_empty", empty, 1'b1);
    chk1("t6_afull0", almost_full, 1'b0);
    chk1("t6_aempty0", almost_empty, 1'b1);
    chk1("t6_udf_held", underflow, 1'b1);
    drive(1'b1, 8'h88, 1'b0, 1'b0, 1'b0); tick();
    chk8("t6_rd_after_flush", rd_data, 8'h88);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); tick();
    chk1("t6_udf_clear", underflow, 1'b0);

    // Set beats clear: pop while empty together with clear_err
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); tick();
    chk1("t6_set_wins", underflow, 1'b1);

    // Reset mid-stream
    drive(1'b1, 8'h91, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h92, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h93, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h94, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h95, 1'b0, 1'b0, 1'b0); tick();
    chk1("t6_ovf_before_rst", overflow, 1'b1);
    reset = 1'b1;
    drive(1'b1, 8'h96, 1'b1, 1'b0, 1'b0); tick();
    reset = 1'b0;
    chkc("t6_rst_count", count, 3'd0);
    chk1("t6_rst_ovf", overflow, 1'b0);
    chk1("t6_rst_udf", underflow, 1'b0);
    chk1("t6_rst_empty", empty, 1'b1);
    chk1("t6_rst_afull", almost_full, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_fifo_ctrl.md
Name: ram_dp_fifo_ctrl

Overview:
- Push/pop FIFO controller that sits directly upstream of the dual-ported synchronous RAM and drives its write-enable, both address ports and its write data.
- Consumes the RAM's secondary output as FIFO read data.
- Provides first-word-fall-through semantics, an occupancy count, almost-full/almost-empty levels, sticky error flags and a flush.
- The RAM instance lives beside this block in the buffer wrapper; only the secondary read port is used for reads.

Parameters:
- DATA_WIDTH, 8: FIFO word width; must match the RAM DATA_WIDTH.
- ADDR_WIDTH, 8: RAM address width. Depth is fixed at DEPTH = 1<<ADDR_WIDTH and is not overridable.
- AFULL_LEVEL, DEPTH-4: almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 4: almost_empty asserts when count <= AEMPTY_LEVEL.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request; wr_data accepted at the edge when not full, or when full with a same-cycle accepted pop.
- wr_data  in  DATA_WIDTH  word to push.
- pop  in  1  read request; head word consumed at the edge when not empty.
- rd_data  out  DATA_WIDTH  head word; equals ram_sdo, valid whenever empty=0.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- almost_full  out  1  registered level flag.
- almost_empty  out  1  registered level flag.
- overflow  out  1  sticky; set by a rejected push.
- underflow  out  1  sticky; set by a pop while empty.
- clear_err  in  1  clears overflow and underflow at the edge.
- flush  in  1  empties the FIFO at the edge.
- ram_we  out  1  RAM write enable.
- ram_pa  out  ADDR_WIDTH  RAM primary address, equal to wr_ptr.
- ram_sa  out  ADDR_WIDTH  RAM secondary address, equal to rd_ptr_next.
- ram_di  out  DATA_WIDTH  RAM write data, equal to wr_data.
- ram_sdo  in  DATA_WIDTH  RAM secondary read data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- RAM model being driven:
  - The RAM registers both addresses at the edge and outputs mem[registered address] combinationally.
  - A write and a registered address to the same location show the new data after that edge.
- Internal pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH-bit and wrap modulo DEPTH (natural overflow, DEPTH-1 -> 0).
  - count is ADDR_WIDTH+1 bits.
- Accept rules:
  - pop_ok = pop & ~empty & ~flush.
  - push_ok = push & ~flush & (~full | pop_ok).
- RAM drive:
  - ram_we = push_ok & ~reset.
  - rd_ptr_next = (reset|flush) ? 0 : rd_ptr + pop_ok. This is combinational, so after every edge ram_sdo presents mem[rd_ptr].
- Edge updates:
  - wr_ptr += push_ok.
  - rd_ptr = rd_ptr_next.
  - count += push_ok - pop_ok; a simultaneous accepted push and pop leaves count unchanged.
- Latency:
  - Push into empty: rd_data is valid and empty=0 in the cycle after the push edge. Zero extra bubble.
  - Pop: the next word is on rd_data in the cycle after the pop edge.
- Level flags:
  - almost_full and almost_empty are registered from next-count, so they change at the same edge as count.
- Full with push and pop in the same cycle: the write lands at wr_ptr==rd_ptr; the old head was consumed this cycle. Count stays DEPTH, overflow is not set.
- Empty with push and pop in the same cycle: the pop is rejected (underflow sets), the push is accepted, count becomes 1.
- Error flags:
  - overflow sets on push & ~flush & full & ~pop_ok.
  - underflow sets on pop & empty & ~flush.
  - clear_err clears both. A same-cycle set wins over clear.
- Flush:
  - wr_ptr, rd_ptr and count go to 0.
  - Same-cycle push and pop are ignored (ram_we=0).
  - Error flags are held.
  - Level flags are recomputed for count=0.
- Reset (at any time, including mid-operation):
  - wr_ptr, rd_ptr, count, overflow and underflow go to 0.
  - empty=1, full=0, almost_full=(AFULL_LEVEL==0), almost_empty=1.
  - ram_we=0 and ram_sa=0 while reset is high.
  - RAM contents are not cleared. rd_data is a don't-care while empty.
- Priority: reset > flush > push/pop.

Test Plan:
All scenarios use ADDR_WIDTH=2 (DEPTH 4), AFULL_LEVEL=3, AEMPTY_LEVEL=1.
1. Reset, then push 0xA1 -> next cycle empty=0, count=1, rd_data=0xA1, almost_empty=1. Pop -> next cycle empty=1, count=0.
2. Push 0x10,0x11,0x12,0x13 -> almost_full=1 at count 3, full=1 at count 4. Push 0x14 -> rejected, overflow=1, count=4. Pop four times -> reads 0x10..0x13 in order.
3. Wrap: push and pop 10 words 0x20..0x29 with at most 2 in flight -> output order exact, pointers wrap with no loss.
4. Full, then push 0x55 with pop in the same cycle -> 0x10 consumed, count stays 4, overflow unchanged, and 0x55 emerges last after 0x11..0x13.
5. Empty, then pop with push 0x66 in the same cycle -> underflow=1, count=1, rd_data=0x66. clear_err -> underflow=0.
6. Count 3, then flush asserted together with push -> next cycle count=0, empty=1, ram_we=0 that cycle, flags held. Assert reset mid-stream -> count=0, overflow=0, underflow=0.
